hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Tracks in-flight destination registers for the EX, MEM and WB stages in an internal shadow pipeline, driven by the ID-stage decode fields.
- Generates load-use stalls, branch/jump flushes and EX-stage forwarding selects.
- Keeps saturating stall/flush performance counters.

Parameters:
- CNT_WIDTH, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1_id  in  5  ID source register 1 (rs).
- id_rs2_id  in  5  ID source register 2 (rt).
- id_rdst_id  in  5  ID destination register.
- id_we_regfile  in  1  ID instruction writes the regfile.
- id_wbsel  in  2  ID writeback select; 1 = load (dmem out).
- id_rs1_used  in  1  ID instruction reads rs.
- id_rs2_used  in  1  ID instruction reads rt (R-type, beq, sw).
- ex_branch_taken  in  1  EX-stage beq taken or j/jal/jr resolved this cycle.
- stall_ext  in  1  external freeze (memory not ready).
- stall_if_id  out  1  hold PC and the IF/ID register.
- bubble_id_ex  out  1  load a NOP into ID/EX.
- flush_if_id  out  1  invalidate the IF/ID register.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB writeback value.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- hazard_err  out  1  sticky flag: a load in MEM matched an EX source (should never occur).
- stall_cnt  out  CNT_WIDTH  cycles with a load-use stall.
- flush_cnt  out  CNT_WIDTH  taken-branch flush events.

Behaviour:
Shadow pipeline
- Three entries: EX, MEM, WB. Each holds {valid, we, rd, is_load}. The EX entry additionally holds rs1, rs2, rs1_used and rs2_used.
- "Writer" means valid && we && rd != 0. Register 0 never matches.
- Advance: each rising edge with stall_ext = 0, WB <= MEM and MEM <= EX.
- EX entry update on advance:
  - If bubble_id_ex = 1, EX <= all-zero entry.
  - Otherwise EX <= ID fields, with is_load = (id_wbsel == 1) and valid = id_valid.
- Freeze: with stall_ext = 1, all entries and counters hold.
  - Outputs: stall_if_id = 1, bubble_id_ex = 0, flush_if_id = 0.
  - ex_branch_taken is ignored; the branch unit holds it until the freeze ends.

Load-use hazard (combinational)
- lu = id_valid && EX is a writer && EX.is_load && ((id_rs1_used && id_rs1_id == EX.rd) || (id_rs2_used && id_rs2_id == EX.rd)).
- When lu = 1: stall_if_id = 1 and bubble_id_ex = 1.
- Exactly one bubble is inserted. On the next cycle the load sits in MEM, lu clears and the value is forwarded from WB.

Control hazard
- When ex_branch_taken = 1: flush_if_id = 1 and bubble_id_ex = 1.
- Branch takes priority over lu: stall_if_id = 0 so the PC can redirect; lu is discarded.
- Penalty: 2 cycles.

Forwarding (combinational from EX/MEM/WB entries)
- fwd_a = 01 if MEM is a writer, !MEM.is_load and MEM.rd == EX.rs1.
- Otherwise fwd_a = 10 if WB is a writer and WB.rd == EX.rs1.
- Otherwise fwd_a = 00.
- fwd_b is identical using EX.rs2.
- If EX.rsN_used = 0 (N = 1 or 2), the corresponding select is forced to 00.
- MEM has priority over WB (the youngest value wins).
- WB-to-ID is not handled: the regfile is write-through.

Error flag
- hazard_err sets on a clock edge if the EX entry is valid and MEM is a writer with is_load and MEM.rd equal to a used EX source.
- It clears only on rst.

Counters
- stall_cnt increments on a non-frozen edge when lu = 1 and ex_branch_taken = 0.
- flush_cnt increments on a non-frozen edge when ex_branch_taken = 1.
- Both saturate at all-ones (no wrap).

Reset
- While rst = 1, all entries are invalid and the counters and hazard_err are 0.
- All outputs are forced to 0 during rst, so fwd_a = fwd_b = 00.
- rst mid-stall drops the pending bubble. The first cycle after rst has no hazards.

Test Plan:
- Load-use: lw r8 followed by add r9,r8,r10.
  - Expect one cycle of stall_if_id = 1 and bubble_id_ex = 1.
  - Next cycle: add in EX with fwd_a = 10 and stall_cnt = 1.
- Back-to-back ALU: add r1,.. then sub r2,r1,r1.
  - No stall; fwd_a = fwd_b = 01.
  - Insert a nop between them: fwd = 10. Use r0 as the destination instead: fwd = 00.
- Priority: MEM and WB both write r5, EX reads r5 -> fwd_a = 01.
  - rs2_used = 0 with a rt match -> fwd_b = 00.
- Branch: ex_branch_taken = 1 coincident with lu = 1.
  - Expect flush_if_id = 1, bubble_id_ex = 1, stall_if_id = 0.
  - flush_cnt = 1, stall_cnt = 0.
- Freeze: stall_ext = 1 for 3 cycles during a load-use.
  - Entries and counters hold; stall_if_id = 1, bubble_id_ex = 0.
  - After release the single bubble is still inserted exactly once.
- Reset and saturation:
  - rst asserted mid-sequence -> all outputs 0 on the following cycle and counters 0.
  - With CNT_WIDTH = 2, 5 stalls -> stall_cnt = 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, branch flushes,
// EX-stage forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [4:0]           id_rs1_id,
    input  logic [4:0]           id_rs2_id,
    input  logic [4:0]           id_rdst_id,
    input  logic                 id_we_regfile,
    input  logic [1:0]           id_wbsel,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 ex_branch_taken,
    input  logic                 stall_ext,
    output logic                 stall_if_id,
    output logic                 bubble_id_ex,
    output logic                 flush_if_id,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 hazard_err,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       is_load;
        logic [4:0] rd;
    } ent_t;

    ent_t                 ex_q, mem_q, wb_q, ex_d;
    logic [4:0]           ex_rs1_q, ex_rs2_q;
    logic                 ex_rs1_used_q, ex_rs2_used_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, stall_cnt_d, flush_cnt_d;
    logic                 hazard_err_q;
    logic                 lu;
    logic                 err_set;

    function automatic logic writer(input ent_t e);
        return e.valid && e.we && (e.rd != 5'd0);
    endfunction

    // A load sitting in MEM cannot forward yet, so only non-loads qualify from MEM.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic used);
        if (!used)
            return 2'b00;
        else if (writer(mem_q) && !mem_q.is_load && (mem_q.rd == src))
            return 2'b01;
        else if (writer(wb_q) && (wb_q.rd == src))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        lu = id_valid && writer(ex_q) && ex_q.is_load &&
             ((id_rs1_used && (id_rs1_id == ex_q.rd)) ||
              (id_rs2_used && (id_rs2_id == ex_q.rd)));
        err_set = ex_q.valid && writer(mem_q) && mem_q.is_load &&
                  ((ex_rs1_used_q && (mem_q.rd == ex_rs1_q)) ||
                   (ex_rs2_used_q && (mem_q.rd == ex_rs2_q)));
    end

    always_comb begin
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        if (rst) begin
            stall_if_id = 1'b0;
        end else if (stall_ext) begin
            stall_if_id = 1'b1;
        end else if (ex_branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (lu) begin
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
    end

    always_comb begin
        fwd_a      = '0;
        fwd_b      = '0;
        hazard_err = 1'b0;
        stall_cnt  = '0;
        flush_cnt  = '0;
        if (!rst) begin
            fwd_a      = fwd_sel(ex_rs1_q, ex_rs1_used_q);
            fwd_b      = fwd_sel(ex_rs2_q, ex_rs2_used_q);
            hazard_err = hazard_err_q;
            stall_cnt  = stall_cnt_q;
            flush_cnt  = flush_cnt_q;
        end
    end

    always_comb begin
        ex_d        = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bubble_id_ex) begin
            ex_d.valid   = id_valid;
            ex_d.we      = id_we_regfile;
            ex_d.is_load = (id_wbsel == 2'd1);
            ex_d.rd      = id_rdst_id;
        end
        if (ex_branch_taken) begin
            if (flush_cnt_q != '1)
                flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end else if (lu) begin
            if (stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            hazard_err_q  <= 1'b0;
        end else begin
            if (err_set)
                hazard_err_q <= 1'b1;
            if (!stall_ext) begin
                wb_q          <= mem_q;
                mem_q         <= ex_q;
                ex_q          <= ex_d;
                ex_rs1_q      <= bubble_id_ex ? 5'd0 : id_rs1_id;
                ex_rs2_q      <= bubble_id_ex ? 5'd0 : id_rs2_id;
                ex_rs1_used_q <= bubble_id_ex ? 1'b0 : id_rs1_used;
                ex_rs2_used_q <= bubble_id_ex ? 1'b0 : id_rs2_used;
                stall_cnt_q   <= stall_cnt_d;
                flush_cnt_q   <= flush_cnt_d;
            end
        end
    end

endmodule
